// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and sizing helpers for the unified-memory arbiter.
package mem_arbiter_pkg;

  // Latency counter covers LAT up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Bits needed to count 0..max_v, never less than one
  function automatic int unsigned streak_width(input int unsigned max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/arb_prio.sv
// Fixed data-over-fetch priority with a starvation override for fetch.
module arb_prio (
  input  logic if_req,
  input  logic dm_req,
  input  logic starve,
  output logic pick_if,
  output logic pick_dm
);

  // Data belongs to the older instruction unless fetch has waited too long
  always_comb begin
    pick_dm = dm_req && !(starve && if_req);
    pick_if = if_req && !pick_dm;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store with
// fixed read latency and a starvation guard for fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 16,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SW = streak_width(STARVE_MAX);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LAT - 1);

  arb_state_e       state;
  arb_owner_e       owner;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    streak;

  logic starve;
  logic pick_if;
  logic pick_dm;
  logic idle;
  logic gnt_if;
  logic gnt_dm;
  logic rd_done;

  assign starve = (streak == STREAK_MAX);

  arb_prio u_arb_prio (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .starve  (starve),
    .pick_if (pick_if),
    .pick_dm (pick_dm)
  );

  // Grants only from IDLE; reset masks every strobe even mid-read
  always_comb begin
    idle    = (state == ARB_IDLE) && !rst;
    gnt_if  = idle && pick_if;
    gnt_dm  = idle && pick_dm;
    rd_done = (state == ARB_WAIT) && (cnt == '0) && !rst;
  end

  always_comb begin
    if_gnt    = gnt_if;
    dm_gnt    = gnt_dm;
    mem_en    = gnt_if || gnt_dm;
    mem_we    = gnt_dm && dm_we;
    mem_addr  = pick_if ? if_addr : dm_addr;
    mem_wdata = dm_wdata;
    if_rvalid = rd_done && (owner == OWN_IF);
    dm_rvalid = rd_done && (owner == OWN_DM);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= OWN_IF;
      cnt    <= '0;
      streak <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          // Writes complete in the grant cycle; only reads occupy WAIT
          if (gnt_if || (gnt_dm && !dm_we)) begin
            state <= ARB_WAIT;
            cnt   <= CNT_LOAD;
            owner <= gnt_if ? OWN_IF : OWN_DM;
          end
        end
        ARB_WAIT: begin
          if (cnt == '0) begin
            state <= ARB_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase

      // Count data wins that left fetch waiting
      if (gnt_if) begin
        streak <= '0;
      end else if (gnt_dm) begin
        if (!if_req) begin
          streak <= '0;
        end else if (!starve) begin
          streak <= streak + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (LAT = 1, 2, 3) each with a memory model and a
// transaction-level reference checked every cycle.
module tb_mem_arbiter;

  localparam int NI = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SM = 3;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
  } op_t;

  typedef struct {
    int          cyc;
    bit          dm;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        if_req   [NI];
  logic [7:0]  if_addr  [NI];
  logic        dm_req   [NI];
  logic        dm_we    [NI];
  logic [7:0]  dm_addr  [NI];
  logic [15:0] dm_wdata [NI];

  logic        if_gnt_a    [NI];
  logic        dm_gnt_a    [NI];
  logic        if_rv_a     [NI];
  logic        dm_rv_a     [NI];
  logic        mem_en_a    [NI];
  logic        mem_we_a    [NI];
  logic [7:0]  mem_addr_a  [NI];
  logic [15:0] mem_wdata_a [NI];
  logic [15:0] if_rdata_a  [NI];
  logic [15:0] dm_rdata_a  [NI];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int act_k    = -1;

  logic [7:0] ifq[$];
  op_t        dmq[$];
  ev_t        gnt_log[$];
  ev_t        rv_log[$];

  int          starve_off[8] = '{0, 1, 2, 3, 6, 7, 8, 9};
  bit          starve_dm[8]  = '{1, 1, 1, 0, 1, 1, 1, 0};
  logic [15:0] alt_data[6]   = '{16'hBEEF, 16'hC0DE, 16'hA511, 16'hA521, 16'hA512, 16'hA522};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    if (a == 32) return 16'hC0DE;
    return {8'hA5, 8'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = g + 1;

    logic [15:0] mem_rdata;
    logic [15:0] pipe [L];
    logic [15:0] marr [256];

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(L), .STARVE_MAX(SM)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_gnt    (if_gnt_a[g]),
      .if_rvalid (if_rv_a[g]),
      .if_rdata  (if_rdata_a[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_gnt    (dm_gnt_a[g]),
      .dm_rvalid (dm_rv_a[g]),
      .dm_rdata  (dm_rdata_a[g]),
      .mem_en    (mem_en_a[g]),
      .mem_we    (mem_we_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata)
    );

    // Memory: read data appears exactly L cycles after the access cycle
    initial begin
      for (int a = 0; a < 256; a++) marr[a] = init_val(a);
      for (int i = 0; i < L; i++) pipe[i] = 16'hDEAD;
    end

    always @(posedge clk) begin
      if (mem_en_a[g] && mem_we_a[g]) marr[mem_addr_a[g]] <= mem_wdata_a[g];
      pipe[0] <= (mem_en_a[g] && !mem_we_a[g]) ? marr[mem_addr_a[g]] : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata = pipe[L-1];

    // Reference: busy-until time, one pending return, starvation count
    logic [15:0] mm [256];
    int          free_at  = 0;
    int          ret_at   = 0;
    int          streak_m = 0;
    bit          pend     = 0;
    bit          ret_dm   = 0;
    logic [15:0] ret_data = '0;
    bit          pif      = 0;
    bit          pdm      = 0;
    logic [7:0]  pia      = '0;
    logic [7:0]  pda      = '0;

    initial for (int a = 0; a < 256; a++) mm[a] = init_val(a);

    always @(negedge clk) begin : model
      bit          e_ig, e_dg, e_irv, e_drv, e_en, e_we, fw, dw;
      logic [7:0]  e_addr;
      logic [15:0] e_wd, e_rd;
      ev_t         ev;
      e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_en = 0; e_we = 0;
      e_addr = '0; e_wd = '0; e_rd = '0;
      if (rst) begin
        pend = 0;
        free_at = cyc + 1;
        streak_m = 0;
      end else begin
        if (pend && ret_at == cyc) begin
          pend = 0;
          e_rd = ret_data;
          if (ret_dm) e_drv = 1; else e_irv = 1;
        end
        if (cyc >= free_at) begin
          fw = if_req[g] && (!dm_req[g] || streak_m == SM);
          dw = dm_req[g] && !fw;
          if (fw) begin
            e_ig = 1; e_en = 1; e_addr = if_addr[g];
            streak_m = 0;
            pend = 1; ret_dm = 0; ret_at = cyc + L; ret_data = mm[if_addr[g]];
            free_at = cyc + L + 1;
          end else if (dw) begin
            e_dg = 1; e_en = 1; e_addr = dm_addr[g]; e_we = dm_we[g]; e_wd = dm_wdata[g];
            streak_m = if_req[g] ? ((streak_m < SM) ? streak_m + 1 : SM) : 0;
            if (dm_we[g]) begin
              mm[dm_addr[g]] = dm_wdata[g];
              free_at = cyc + 1;
            end else begin
              pend = 1; ret_dm = 1; ret_at = cyc + L; ret_data = mm[dm_addr[g]];
              free_at = cyc + L + 1;
            end
          end
        end
      end

      chk($sformatf("L%0d if_gnt", L), 32'(if_gnt_a[g]), 32'(e_ig));
      chk($sformatf("L%0d dm_gnt", L), 32'(dm_gnt_a[g]), 32'(e_dg));
      chk($sformatf("L%0d if_rvalid", L), 32'(if_rv_a[g]), 32'(e_irv));
      chk($sformatf("L%0d dm_rvalid", L), 32'(dm_rv_a[g]), 32'(e_drv));
      chk($sformatf("L%0d mem_en", L), 32'(mem_en_a[g]), 32'(e_en));
      chk($sformatf("L%0d mem_we", L), 32'(mem_we_a[g]), 32'(e_we));
      if (e_en) chk($sformatf("L%0d mem_addr", L), 32'(mem_addr_a[g]), 32'(e_addr));
      if (e_we) chk($sformatf("L%0d mem_wdata", L), 32'(mem_wdata_a[g]), 32'(e_wd));
      if (e_irv) chk($sformatf("L%0d if_rdata", L), 32'(if_rdata_a[g]), 32'(e_rd));
      if (e_drv) chk($sformatf("L%0d dm_rdata", L), 32'(dm_rdata_a[g]), 32'(e_rd));

      // Requesters must hold request and address until granted
      if (!rst && pif) chk($sformatf("L%0d if_req held", L), 32'(if_req[g] && if_addr[g] == pia), 32'd1);
      if (!rst && pdm) chk($sformatf("L%0d dm_req held", L), 32'(dm_req[g] && dm_addr[g] == pda), 32'd1);
      pif = !rst && if_req[g] && !if_gnt_a[g];
      pdm = !rst && dm_req[g] && !dm_gnt_a[g];
      pia = if_addr[g];
      pda = dm_addr[g];

      if (g == act_k && !rst) begin
        if (if_gnt_a[g] || dm_gnt_a[g]) begin
          ev.cyc = cyc; ev.dm = dm_gnt_a[g]; ev.we = mem_we_a[g];
          ev.addr = mem_addr_a[g]; ev.data = mem_wdata_a[g];
          gnt_log.push_back(ev);
        end
        if (if_rv_a[g] || dm_rv_a[g]) begin
          ev.cyc = cyc; ev.dm = dm_rv_a[g]; ev.we = 0; ev.addr = '0;
          ev.data = dm_rv_a[g] ? dm_rdata_a[g] : if_rdata_a[g];
          rv_log.push_back(ev);
        end
      end
    end
  end

  // Present queue heads, pop on grant; entered and left at posedge+1
  task automatic run_q(input int k);
    bit gi_s, gd_s;
    for (int n = 0; n < 200 && (ifq.size() > 0 || dmq.size() > 0); n++) begin
      if_req[k] = ifq.size() > 0;
      if (ifq.size() > 0) if_addr[k] = ifq[0];
      dm_req[k] = dmq.size() > 0;
      if (dmq.size() > 0) begin
        dm_we[k] = dmq[0].we; dm_addr[k] = dmq[0].addr; dm_wdata[k] = dmq[0].data;
      end
      @(negedge clk);
      gi_s = if_gnt_a[k];
      gd_s = dm_gnt_a[k];
      @(posedge clk); #1;
      if (gi_s) void'(ifq.pop_front());
      if (gd_s) void'(dmq.pop_front());
    end
    if_req[k] = 0;
    dm_req[k] = 0;
    chk("request queue drained", 32'(ifq.size() + dmq.size()), 32'd0);
    ifq.delete();
    dmq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int k);
    act_k = k;
    gnt_log.delete();
    rv_log.delete();
  endtask

  task automatic push_dm(input bit we, input logic [7:0] a, input logic [15:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    dmq.push_back(o);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 0; if_addr[k] = '0; dm_req[k] = 0;
      dm_we[k] = 0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    // Requests held during reset must not be granted
    if_req[0] = 1; if_addr[0] = 8'h10;
    dm_req[0] = 1; dm_addr[0] = 8'h33;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst if_gnt", 32'(if_gnt_a[0]), 32'd0);
    chk("rst dm_gnt", 32'(dm_gnt_a[0]), 32'd0);
    chk("rst mem_en", 32'(mem_en_a[0]), 32'd0);
    @(posedge clk); #1;
    rst = 0; if_req[0] = 0; dm_req[0] = 0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("post-rst mem_en", 32'(mem_en_a[k]), 32'd0);
      chk("post-rst rvalid", 32'(if_rv_a[k] | dm_rv_a[k]), 32'd0);
    end
    @(posedge clk); #1;

    // Fetch-only read, LAT=2
    start(1);
    ifq.push_back(8'h10);
    run_q(1); idle(6);
    chk("t1 grants", 32'(gnt_log.size()), 32'd1);
    chk("t1 returns", 32'(rv_log.size()), 32'd1);
    if (gnt_log.size() == 1 && rv_log.size() == 1) begin
      chk("t1 grant port", 32'(gnt_log[0].dm), 32'd0);
      chk("t1 return port", 32'(rv_log[0].dm), 32'd0);
      chk("t1 latency", 32'(rv_log[0].cyc - gnt_log[0].cyc), 32'd2);
      chk("t1 data", 32'(rv_log[0].data), 32'hBEEF);
    end

    // Simultaneous fetch and LW: data first, fetch three cycles later
    start(1);
    ifq.push_back(8'h11);
    push_dm(0, 8'h20, 16'h0);
    run_q(1); idle(6);
    chk("t2 grants", 32'(gnt_log.size()), 32'd2);
    chk("t2 returns", 32'(rv_log.size()), 32'd2);
    if (gnt_log.size() == 2 && rv_log.size() == 2) begin
      chk("t2 first is data", 32'(gnt_log[0].dm), 32'd1);
      chk("t2 second is fetch", 32'(gnt_log[1].dm), 32'd0);
      chk("t2 fetch gap", 32'(gnt_log[1].cyc - gnt_log[0].cyc), 32'd3);
      chk("t2 load time", 32'(rv_log[0].cyc - gnt_log[0].cyc), 32'd2);
      chk("t2 load data", 32'(rv_log[0].data), 32'hC0DE);
      chk("t2 fetch data", 32'(rv_log[1].data), 32'hA511);
    end

    // Starvation guard: three SWs then fetch, twice
    start(1);
    ifq.push_back(8'h30); ifq.push_back(8'h31);
    for (int i = 0; i < 6; i++) push_dm(1, 8'(8'h40 + i), 16'(16'h1000 + i));
    run_q(1); idle(6);
    chk("t3 grants", 32'(gnt_log.size()), 32'd8);
    if (gnt_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t3 port %0d", i), 32'(gnt_log[i].dm), 32'(starve_dm[i]));
        chk($sformatf("t3 offset %0d", i), 32'(gnt_log[i].cyc - gnt_log[0].cyc), 32'(starve_off[i]));
      end
    end
    chk("t3 returns", 32'(rv_log.size()), 32'd2);
    if (rv_log.size() == 2) chk("t3 fetch data", 32'(rv_log[1].data), 32'hA531);

    // SW to 0x05, then read it back
    start(1);
    push_dm(1, 8'h05, 16'h1234);
    run_q(1); idle(5);
    chk("t4 grants", 32'(gnt_log.size()), 32'd1);
    if (gnt_log.size() == 1) begin
      chk("t4 we", 32'(gnt_log[0].we), 32'd1);
      chk("t4 addr", 32'(gnt_log[0].addr), 32'h05);
      chk("t4 wdata", 32'(gnt_log[0].data), 32'h1234);
    end
    chk("t4 no rvalid", 32'(rv_log.size()), 32'd0);
    start(1);
    push_dm(0, 8'h05, 16'h0);
    run_q(1); idle(4);
    chk("t4 readback count", 32'(rv_log.size()), 32'd1);
    if (rv_log.size() == 1) chk("t4 readback", 32'(rv_log[0].data), 32'h1234);

    // Reset one cycle after a LAT=3 read grant aborts it
    start(2);
    ifq.push_back(8'h10);
    run_q(2);
    rst = 1;
    idle(1);
    rst = 0;
    @(negedge clk);
    chk("t5 if_gnt", 32'(if_gnt_a[2]), 32'd0);
    chk("t5 dm_gnt", 32'(dm_gnt_a[2]), 32'd0);
    chk("t5 rvalid", 32'(if_rv_a[2] | dm_rv_a[2]), 32'd0);
    chk("t5 mem_en", 32'(mem_en_a[2]), 32'd0);
    chk("t5 mem_we", 32'(mem_we_a[2]), 32'd0);
    @(posedge clk); #1;
    idle(6);
    chk("t5 aborted read", 32'(rv_log.size()), 32'd0);
    start(2);
    ifq.push_back(8'h11);
    run_q(2); idle(6);
    chk("t5 recovery count", 32'(rv_log.size()), 32'd1);
    if (rv_log.size() == 1 && gnt_log.size() == 1) begin
      chk("t5 recovery latency", 32'(rv_log[0].cyc - gnt_log[0].cyc), 32'd3);
      chk("t5 recovery data", 32'(rv_log[0].data), 32'hA511);
    end

    // LAT=1 alternating fetch/load reads
    start(0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) ifq.push_back(8'(8'h10 + i / 2));
      else push_dm(0, 8'(8'h20 + i / 2), 16'h0);
      run_q(0);
    end
    idle(4);
    chk("t6 grants", 32'(gnt_log.size()), 32'd6);
    chk("t6 returns", 32'(rv_log.size()), 32'd6);
    if (gnt_log.size() == 6 && rv_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t6 grant port %0d", i), 32'(gnt_log[i].dm), 32'(i % 2));
        chk($sformatf("t6 grant time %0d", i), 32'(gnt_log[i].cyc - gnt_log[0].cyc), 32'(2 * i));
        chk($sformatf("t6 return time %0d", i), 32'(rv_log[i].cyc - gnt_log[i].cyc), 32'd1);
        chk($sformatf("t6 return port %0d", i), 32'(rv_log[i].dm), 32'(i % 2));
        chk($sformatf("t6 return data %0d", i), 32'(rv_log[i].data), 32'(alt_data[i]));
      end
    end

    act_k = -1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
